// File: rtl/nibble_serializer_pkg.sv
// Shared types and defaults for the nibble serializer slice.
// The FSM state encoding is fixed here so that the serializer and its future deserializer agree.
package nibble_serializer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_serializer_if.sv
// Word-in / bit-out handshake bundle for the nibble serializer.
// The serializer uses the slave view; the word producer and bit consumer use the master view.
interface nibble_serializer_if #(
    parameter int WIDTH = nibble_serializer_pkg::WIDTH_DEFAULT
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_first;
    logic             sout_last;
    logic             sout_ready;
    logic             busy;

    modport slave (
        input  in_data, in_valid, sout_ready,
        output in_ready, sout, sout_valid, sout_first, sout_last, busy
    );

    modport master (
        output in_data, in_valid, sout_ready,
        input  in_ready, sout, sout_valid, sout_first, sout_last, busy
    );
endinterface

// File: rtl/nibble_serializer_shift_reg_load.sv
// Loadable shift register that presents one end as the serial bit.
// The register shifts toward the output end and fills with zeros.
module shift_reg_load #(
    parameter int WIDTH     = nibble_serializer_pkg::WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             bit_out
);
    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            sh <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
        end
    end

    assign bit_out = MSB_FIRST ? sh[WIDTH-1] : sh[0];
endmodule

// File: rtl/nibble_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake, one bit per cycle out,
// with first/last framing and zero-gap back-to-back streaming.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    nibble_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          first_q, first_d;
    logic          load, shift;
    logic          sh_bit;
    logic          in_shift, cnt_zero;
    logic          word_xfer, bit_xfer;

    shift_reg_load #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_sh (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
        .din    (bus.in_data),
        .bit_out(sh_bit)
    );

    assign in_shift  = (state_q == SHIFT);
    assign cnt_zero  = (cnt_q == '0);
    assign bit_xfer  = in_shift && bus.sout_ready;
    assign word_xfer = bus.in_valid && bus.in_ready;

    // Accepting during the last bit lets the next word follow without a bubble.
    assign bus.in_ready   = !in_shift || (cnt_zero && bus.sout_ready);
    assign bus.sout_valid = in_shift;
    assign bus.sout       = in_shift && sh_bit;
    assign bus.sout_first = in_shift && first_q;
    assign bus.sout_last  = in_shift && cnt_zero;
    assign bus.busy       = in_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (word_xfer) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    first_d = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_xfer) begin
                    if (!cnt_zero) begin
                        shift   = 1'b1;
                        cnt_d   = cnt_q - CW'(1);
                        first_d = 1'b0;
                    end else if (word_xfer) begin
                        load    = 1'b1;
                        cnt_d   = CW'(WIDTH - 1);
                        first_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_nibble_serializer.sv
// Scoreboard bench for nibble_serializer: directed words, expected bit frames queued at issue,
// monitors compare every bit transfer; cycle-level control checks in the stimulus thread.
module tb_nibble_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serializer_if #(.WIDTH(4)) b0 ();
    nibble_serializer_if #(.WIDTH(4)) b1 ();

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int errors = 0;
    int checks = 0;

    // Entries are {bit, first, last} in emission order.
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // seq lists the emitted bits with seq[3] leaving first.
    task automatic push_exp(input int which, input logic [3:0] seq);
        for (int i = 0; i < 4; i++) begin
            if (which == 0) q0.push_back({seq[3-i], i == 0, i == 3});
            else            q1.push_back({seq[3-i], i == 0, i == 3});
        end
    endtask

    always @(negedge clk) begin
        if (!rst && b0.sout_valid && b0.sout_ready) begin
            if (q0.size() == 0) chk("dut0 unexpected bit", 32'(b0.sout), 32'hdead);
            else chk("dut0 bit/first/last", 32'({b0.sout, b0.sout_first, b0.sout_last}), 32'(q0.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.sout_valid && b1.sout_ready) begin
            if (q1.size() == 0) chk("dut1 unexpected bit", 32'(b1.sout), 32'hdead);
            else chk("dut1 bit/first/last", 32'({b1.sout, b1.sout_first, b1.sout_last}), 32'(q1.pop_front()));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b0.in_data = '0; b0.in_valid = 1'b0; b0.sout_ready = 1'b1;
        b1.in_data = '0; b1.in_valid = 1'b0; b1.sout_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset in_ready", 32'(b0.in_ready), 32'd1);
        chk("reset sout_valid", 32'(b0.sout_valid), 32'd0);
        chk("reset busy", 32'(b0.busy), 32'd0);
        chk("reset sout/first/last", 32'({b0.sout, b0.sout_first, b0.sout_last}), 32'd0);

        // Idle hold
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            chk("idle sout_valid", 32'(b0.sout_valid), 32'd0);
            chk("idle sout", 32'(b0.sout), 32'd0);
            chk("idle in_ready", 32'(b0.in_ready), 32'd1);
        end
        next_cycle();

        // Single word 1010, MSB first
        push_exp(0, 4'b1010);
        b0.in_data = 4'b1010; b0.in_valid = 1'b1;
        next_cycle();
        b0.in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("single in_ready", 32'(b0.in_ready), 32'(c == 4));
            chk("single busy", 32'(b0.busy), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        chk("single busy after", 32'(b0.busy), 32'd0);
        chk("single valid after", 32'(b0.sout_valid), 32'd0);
        next_cycle();

        // Back-to-back 0001 then 1000
        push_exp(0, 4'b0001);
        push_exp(0, 4'b1000);
        b0.in_data = 4'b0001; b0.in_valid = 1'b1;
        next_cycle();
        b0.in_data = 4'b1000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("b2b sout_valid", 32'(b0.sout_valid), 32'd1);
            if (c == 4) chk("b2b in_ready cycle4", 32'(b0.in_ready), 32'd1);
            next_cycle();
            if (c == 4) b0.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b idle after", 32'(b0.sout_valid), 32'd0);
        next_cycle();

        // Stall in cycles 2-3
        push_exp(0, 4'b1010);
        b0.in_data = 4'b1010; b0.in_valid = 1'b1;
        next_cycle();
        b0.in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            b0.sout_ready = (c != 2 && c != 3);
            @(negedge clk);
            if (c >= 2 && c <= 4)
                chk("stall hold", 32'({b0.sout_valid, b0.sout, b0.sout_first, b0.sout_last}), 32'b1000);
            if (c == 6) chk("stall last cycle6", 32'({b0.sout_valid, b0.sout_last}), 32'b11);
            if (c == 7) chk("stall done", 32'(b0.sout_valid), 32'd0);
            next_cycle();
        end
        b0.sout_ready = 1'b1;

        // Reset mid-word: only the first bit of 1110 is delivered
        q0.push_back(3'b110);
        b0.in_data = 4'b1110; b0.in_valid = 1'b1;
        next_cycle();
        b0.in_valid = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("midreset sout_valid", 32'(b0.sout_valid), 32'd0);
        chk("midreset in_ready", 32'(b0.in_ready), 32'd1);
        chk("midreset busy", 32'(b0.busy), 32'd0);
        chk("midreset dropped word", 32'(q0.size()), 32'd0);
        push_exp(0, 4'b0001);
        b0.in_data = 4'b0001; b0.in_valid = 1'b1;
        next_cycle();
        b0.in_valid = 1'b0;
        repeat (5) next_cycle();

        // LSB first: 1110 leaves as 0,1,1,1
        push_exp(1, 4'b0111);
        b1.in_data = 4'b1110; b1.in_valid = 1'b1;
        next_cycle();
        b1.in_valid = 1'b0;
        repeat (5) next_cycle();

        @(negedge clk);
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
